// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM encoding, command bytes and frame payload.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_REL
  } state_t;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] ACK_BYTE   = 8'hFA;

  // Payload shifted out after the start bit, LSB of data first, parity last.
  typedef struct packed {
    logic       par;
    logic [7:0] data;
  } tx_frame_t;

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 pad conditioning: 2-flop synchronizers, clock majority-free run-length filter, fall strobe.
module ps2_clk_filter #(
  parameter int unsigned FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic c_raw,
  input  logic d_raw,
  input  logic clr,
  output logic c_sync,
  output logic d_sync,
  output logic fall
);

  logic                c_meta;
  logic                d_meta;
  logic                c_filt;
  logic [FILT_LEN-1:0] hist;
  logic                all_one;
  logic                all_zero;

  assign all_one  = &hist;
  assign all_zero = ~|hist;

  // Idle PS/2 lines are pulled high, so the history resets to ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_meta <= 1'b1;
      c_sync <= 1'b1;
      d_meta <= 1'b1;
      d_sync <= 1'b1;
      hist   <= '1;
      c_filt <= 1'b1;
      fall   <= 1'b0;
    end else begin
      c_meta <= c_raw;
      c_sync <= c_meta;
      d_meta <= d_raw;
      d_sync <= d_meta;
      hist   <= {hist[FILT_LEN-2:0], c_sync};
      if (all_one) begin
        c_filt <= 1'b1;
      end else if (all_zero) begin
        c_filt <= 1'b0;
      end
      fall <= c_filt & all_zero & ~clr;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out one byte on device falls, check ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned FILT_LEN       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout,
  input  logic       ps2_c_in,
  input  logic       ps2_d_in,
  output logic       ps2_c_oe,
  output logic       ps2_d_oe
);

  localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] I_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_n;
  logic [IW-1:0] icnt, icnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [3:0]    bcnt, bcnt_n;
  logic [8:0]    sh, sh_n;
  logic          busy_n, done_n, ack_err_n, timeout_n, c_oe_n, d_oe_n;
  logic          c_sync, d_sync, fall;
  tx_frame_t     frame_ld;

  ps2_clk_filter #(
    .FILT_LEN(FILT_LEN)
  ) u_filt (
    .clk   (clk),
    .rst   (rst),
    .c_raw (ps2_c_in),
    .d_raw (ps2_d_in),
    .clr   (state == REQ),
    .c_sync(c_sync),
    .d_sync(d_sync),
    .fall  (fall)
  );

  assign frame_ld = '{par: odd_par(tx_data), data: tx_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      icnt     <= '0;
      tcnt     <= '0;
      bcnt     <= '0;
      sh       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      timeout  <= 1'b0;
      ps2_c_oe <= 1'b0;
      ps2_d_oe <= 1'b0;
    end else begin
      state    <= state_n;
      icnt     <= icnt_n;
      tcnt     <= tcnt_n;
      bcnt     <= bcnt_n;
      sh       <= sh_n;
      busy     <= busy_n;
      done     <= done_n;
      ack_err  <= ack_err_n;
      timeout  <= timeout_n;
      ps2_c_oe <= c_oe_n;
      ps2_d_oe <= d_oe_n;
    end
  end

  always_comb begin
    state_n   = state;
    icnt_n    = icnt;
    tcnt_n    = tcnt;
    bcnt_n    = bcnt;
    sh_n      = sh;
    busy_n    = busy;
    done_n    = 1'b0;
    ack_err_n = ack_err;
    timeout_n = 1'b0;
    c_oe_n    = ps2_c_oe;
    d_oe_n    = ps2_d_oe;

    unique case (state)
      IDLE: begin
        c_oe_n = 1'b0;
        d_oe_n = 1'b0;
        if (tx_start) begin
          sh_n      = frame_ld;
          busy_n    = 1'b1;
          ack_err_n = 1'b0;
          icnt_n    = '0;
          state_n   = INHIBIT;
        end
      end

      INHIBIT: begin
        c_oe_n = 1'b1;
        if (icnt == I_LAST) begin
          d_oe_n  = 1'b1;
          state_n = REQ;
        end else begin
          icnt_n = icnt + IW'(1);
        end
      end

      REQ: begin
        c_oe_n  = 1'b0;
        d_oe_n  = 1'b1;
        bcnt_n  = '0;
        tcnt_n  = '0;
        state_n = SHIFT;
      end

      SHIFT, ACK, WAIT_REL: begin
        // Timeout takes priority over any fall in the same cycle.
        if (tcnt == T_LAST) begin
          c_oe_n    = 1'b0;
          d_oe_n    = 1'b0;
          timeout_n = 1'b1;
          busy_n    = 1'b0;
          state_n   = IDLE;
        end else begin
          tcnt_n = tcnt + TW'(1);
          unique case (state)
            SHIFT: begin
              if (fall) begin
                bcnt_n = bcnt + 4'd1;
                if (bcnt < 4'd9) begin
                  d_oe_n = ~sh[0];
                  sh_n   = {1'b0, sh[8:1]};
                end else begin
                  d_oe_n  = 1'b0;
                  state_n = ACK;
                end
              end
            end
            ACK: begin
              if (fall) begin
                ack_err_n = d_sync;
                state_n   = WAIT_REL;
              end
            end
            default: begin
              if (c_sync && d_sync) begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
              end
            end
          endcase
        end
      end

      default: begin
        c_oe_n  = 1'b0;
        d_oe_n  = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

endmodule
